// File: rtl/gpio_pkg.sv
// Register-map word indices and parameter limits shared by the APB GPIO block.
package gpio_pkg;

  localparam int GPIO_WIDTH_MIN = 1;
  localparam int GPIO_WIDTH_MAX = 32;
  localparam int GPIO_SYNC_MIN  = 2;
  localparam int GPIO_SYNC_MAX  = 3;

  typedef enum logic [3:0] {
    REG_MODER = 4'd0,
    REG_IDR   = 4'd1,
    REG_ODR   = 4'd2,
    REG_SET   = 4'd3,
    REG_CLR   = 4'd4,
    REG_IER   = 4'd5,
    REG_RISE  = 4'd6,
    REG_FALL  = 4'd7,
    REG_ISR   = 4'd8
  } gpio_reg_e;

  function automatic gpio_reg_e word_index(input logic [5:0] addr);
    return gpio_reg_e'(addr[5:2]);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin synchronizer plus one-cycle delay copy; produces rise/fall pulses on the synchronized value.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_dly;

  // Synchronizer chain and delayed copy of its last stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_dly <= '0;
    end else begin
      r_sync[0] <= i_pins;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_dly <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_dly;
  assign o_fall = ~o_sync & r_dly;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB-mapped GPIO with per-pin direction, set/clear output access and edge interrupts.
module apb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [5:0]       PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  inout  wire  [WIDTH-1:0] inoutPort,
  output logic             irq
);

  logic [WIDTH-1:0] r_moder, r_odr, r_ier, r_rise, r_fall, r_isr;
  logic [31:0]      r_prdata;
  logic             r_pready;

  logic             w_access;
  gpio_reg_e        w_idx;
  logic [WIDTH-1:0] w_wdata, w_idr, w_rise_p, w_fall_p, w_set_ev, w_w1c;
  logic [31:0]      w_rdata;
  logic             w_unused;

  gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_pins  (inoutPort),
    .o_sync  (w_idr),
    .o_rise  (w_rise_p),
    .o_fall  (w_fall_p)
  );

  // The PREADY term keeps a held PENABLE from completing the same transfer twice.
  assign w_access = PSEL & PENABLE & ~r_pready;
  assign w_idx    = word_index(PADDR);
  assign w_wdata  = PWDATA[WIDTH-1:0];
  assign w_set_ev = (w_rise_p & r_rise) | (w_fall_p & r_fall);
  assign w_unused = ^{PADDR[1:0], PWDATA};

  // W1C mask for ISR, non-zero only during a committing ISR write.
  always_comb begin
    w_w1c = '0;
    if (w_access && PWRITE && (w_idx == REG_ISR)) begin
      w_w1c = w_wdata;
    end else begin
      w_w1c = '0;
    end
  end

  // Read mux; write-only and unmapped offsets return zero.
  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      REG_MODER: w_rdata[WIDTH-1:0] = r_moder;
      REG_IDR:   w_rdata[WIDTH-1:0] = w_idr;
      REG_ODR:   w_rdata[WIDTH-1:0] = r_odr;
      REG_IER:   w_rdata[WIDTH-1:0] = r_ier;
      REG_RISE:  w_rdata[WIDTH-1:0] = r_rise;
      REG_FALL:  w_rdata[WIDTH-1:0] = r_fall;
      REG_ISR:   w_rdata[WIDTH-1:0] = r_isr;
      default:   w_rdata = 32'd0;
    endcase
  end

  // Register file, APB handshake and interrupt status.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_moder  <= '0;
      r_odr    <= '0;
      r_ier    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_isr    <= '0;
      r_prdata <= 32'd0;
      r_pready <= 1'b0;
    end else begin
      r_pready <= w_access;
      // Set is OR-ed after the clear so a coincident edge event wins.
      r_isr    <= (r_isr & ~w_w1c) | w_set_ev;
      if (w_access && PWRITE) begin
        case (w_idx)
          REG_MODER: r_moder <= w_wdata;
          REG_ODR:   r_odr   <= w_wdata;
          REG_SET:   r_odr   <= r_odr | w_wdata;
          REG_CLR:   r_odr   <= r_odr & ~w_wdata;
          REG_IER:   r_ier   <= w_wdata;
          REG_RISE:  r_rise  <= w_wdata;
          REG_FALL:  r_fall  <= w_wdata;
          default:   ;
        endcase
      end
      if (w_access && !PWRITE) begin
        r_prdata <= w_rdata;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign inoutPort[g] = r_moder[g] ? r_odr[g] : 1'bz;
  end

  assign PRDATA = r_prdata;
  assign PREADY = r_pready;
  assign irq    = |(r_isr & r_ier);

endmodule

// File: doc/apb_gpio_irq.md
APB_GPIO_IRQ -- requirements
Module: apb_gpio_irq

Interface
REQ-001 Parameter WIDTH, default 8, meaning number of GPIO pins; the legal range is 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, meaning input synchronizer depth; the legal range is 2..3.
REQ-003 PCLK  in  1  single clock; all state SHALL change on the rising edge only.
REQ-004 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 PADDR  in  6  byte address; bits [1:0] SHALL be ignored.
REQ-006 PWDATA  in  32  write data.
REQ-007 PWRITE, PENABLE, PSEL  in  1 each  APB control.
REQ-008 PRDATA  out  32  registered read data.
REQ-009 PREADY  out  1  registered transfer-complete strobe.
REQ-010 inoutPort  inout  WIDTH  pins; bit i SHALL be driven with ODR[i] when MODER[i]=1, else high-Z.
REQ-011 irq  out  1  level interrupt, equal to |(ISR & IER).

Function
REQ-012 Register map, by word offset:
- 0x00 MODER RW, 1 = output.
- 0x04 IDR RO, synchronized pin value.
- 0x08 ODR RW.
- 0x0C SET WO, ODR |= data.
- 0x10 CLR WO, ODR &= ~data.
- 0x14 IER RW.
- 0x18 RISE RW.
- 0x1C FALL RW.
- 0x20 ISR RW1C.
REQ-013 Reads of WO or unmapped offsets SHALL return 0; writes to RO or unmapped offsets SHALL be ignored; register bits at or above WIDTH SHALL read 0.
REQ-014 Access phase is PSEL&PENABLE&!PREADY; on that edge PREADY SHALL go to 1 for exactly one cycle, the write SHALL commit, and PRDATA SHALL load.
REQ-015 Each transfer SHALL therefore take 3 PCLK cycles from setup; a write SHALL commit exactly once even if PENABLE stays high.
REQ-016 PREADY SHALL be 0 in every cycle without a completing access; PRDATA SHALL hold its value between reads.
REQ-017 Pins SHALL pass through SYNC_STAGES flops; IDR SHALL reflect a pin change SYNC_STAGES cycles after the first capturing edge.
REQ-018 Edge detect SHALL compare the synchronized value with its 1-cycle-delayed copy, on every pin regardless of MODER.
REQ-019 ISR[i] SHALL set on the edge after a detected rise with RISE[i]=1, or after a detected fall with FALL[i]=1.
REQ-020 ISR[i] SHALL set independently of IER[i]; IER only masks irq.
REQ-021 If a set event and a W1C of the same ISR bit occur in the same cycle, the set SHALL win.
REQ-022 If a SET and a CLR target the same cycle, there is no conflict, because only one APB write is possible per cycle.
REQ-023 irq SHALL be combinational from the ISR and IER flops (no extra latency) and SHALL stay high until the pending enabled bits are cleared or masked.
REQ-024 When MODER[i] toggles, the pin SHALL switch drive/high-Z combinationally in the same cycle as the register update.

Reset
REQ-025 PRESETn=0 SHALL asynchronously clear MODER, ODR, IER, RISE, FALL, ISR, all synchronizer and delay flops, PRDATA and PREADY.
REQ-026 After reset all pins SHALL be high-Z and irq=0.
REQ-027 A pin already high at reset release SHALL NOT set ISR, because RISE=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no register write.

Structure
REQ-029 Package gpio_pkg SHALL hold the register offset localparams (enum of word indices) and WIDTH limits.
REQ-030 Sub-module gpio_sync_edge SHALL hold the synchronizer, delay flop and rise/fall pulse outputs, parametrised by WIDTH and SYNC_STAGES.
REQ-031 The APB decode, register file and tristate drivers SHALL stay in apb_gpio_irq.

Verification
REQ-032 Write MODER=0xFF, then ODR=0x5A -> inoutPort=0x5A; SET 0x01 -> 0x5B; CLR 0x50 -> 0x0B; each write PREADY high exactly 1 cycle.
REQ-033 MODER=0x00 with pins externally driven 0x3C -> IDR reads 0x3C no earlier than SYNC_STAGES+1 cycles after the pin change; inoutPort released (Z) by the DUT.
REQ-034 RISE=0x01, IER=0x01, pin0 0->1 -> ISR=0x01 and irq=1; write ISR=0x01 -> ISR=0, irq=0; pin0 1->0 -> no ISR set.
REQ-035 FALL=0x80 with a pin7 falling edge aligned to a W1C of ISR bit 7 -> ISR[7]=1 after that cycle (set wins).
REQ-036 Read offset 0x0C and 0x3C -> PRDATA=0; WIDTH=4 build: write MODER=0xFFFFFFFF -> reads 0x0000000F.
REQ-037 Assert PRESETn low during a PSEL/PENABLE write of ODR=0xFF -> ODR=0, PREADY=0, pins Z, irq=0 immediately.
